// File: rtl/legv8_multicycle_ctrl_pkg.sv
// Shared types, ALU function codes and opcode match patterns for the LEGv8
// multi-cycle controller; the opcode patterns are also used by the sign extender.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OPC_R, OPC_LSL, OPC_LDUR, OPC_STUR, OPC_B, OPC_CBZ
  } op_class_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] IMM_D     = 2'b00;
  localparam logic [1:0] IMM_CB    = 2'b01;
  localparam logic [1:0] IMM_B     = 2'b10;
  localparam logic [1:0] IMM_SHAMT = 2'b11;

  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  // R-type table: entry i pairs an opcode with its ALU function.
  localparam int N_RTYPE = 4;
  localparam logic [N_RTYPE-1:0][10:0] RTYPE_OPC = {OP_ORR, OP_AND, OP_SUB, OP_ADD};
  localparam logic [N_RTYPE-1:0][3:0]  RTYPE_ALU = {ALU_ORR, ALU_AND, ALU_SUB, ALU_ADD};

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath
// (slave): instruction/flag inputs and all control strobes.
interface legv8_ctrl_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        mem_ready;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCSrc;
  logic [1:0]  ImmSel;
  logic        ALUSrcB;
  logic [3:0]  ALUOp;
  logic        Reg2Loc;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic        RegWrite;
  logic        fault;
  logic [2:0]  state;

  modport master (
    input  Instr, Zero, mem_ready,
    output IRWrite, PCWrite, PCSrc, ImmSel, ALUSrcB, ALUOp, Reg2Loc,
           MemRead, MemWrite, MemToReg, RegWrite, fault, state
  );

  modport slave (
    output Instr, Zero, mem_ready,
    input  IRWrite, PCWrite, PCSrc, ImmSel, ALUSrcB, ALUOp, Reg2Loc,
           MemRead, MemWrite, MemToReg, RegWrite, fault, state
  );
endinterface

// File: rtl/legv8_multicycle_ctrl_op_decode.sv
// Combinational opcode decode: instruction class, ALU function, immediate
// format and an illegal-opcode flag from Instr[31:21].
module legv8_op_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class,
  output logic [3:0]  alu_op,
  output logic [1:0]  imm_sel,
  output logic        illegal
);

  logic [N_RTYPE-1:0] r_hit;

  generate
    for (genvar gi = 0; gi < N_RTYPE; gi++) begin : g_rtype
      assign r_hit[gi] = (opcode == RTYPE_OPC[gi]);
    end
  endgenerate

  always_comb begin
    op_class = OPC_R;
    alu_op   = ALU_AND;
    imm_sel  = IMM_D;
    illegal  = 1'b0;
    if (opcode[10:5] == OP_B) begin
      op_class = OPC_B;
      imm_sel  = IMM_B;
    end else if (opcode[10:3] == OP_CBZ) begin
      op_class = OPC_CBZ;
      alu_op   = ALU_PASSB;
      imm_sel  = IMM_CB;
    end else if (opcode == OP_LDUR) begin
      op_class = OPC_LDUR;
      alu_op   = ALU_ADD;
    end else if (opcode == OP_STUR) begin
      op_class = OPC_STUR;
      alu_op   = ALU_ADD;
    end else if (opcode == OP_LSL) begin
      op_class = OPC_LSL;
      alu_op   = ALU_LSL;
      imm_sel  = IMM_SHAMT;
    end else if (|r_hit) begin
      for (int i = 0; i < N_RTYPE; i++) begin
        if (r_hit[i]) alu_op = RTYPE_ALU[i];
      end
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multi-cycle control FSM: fetch/decode/exec/mem/writeback over one
// memory port, with a mem_ready wait timeout that latches a sticky fault.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic          CLK,
  input  logic          resetl,
  legv8_ctrl_if.master  bus
);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              fault_reg;

  op_class_t  dec_class;
  logic [3:0] dec_alu;
  logic [1:0] dec_imm;
  logic       dec_illegal;

  logic       ir_write, pc_write, pc_src, alu_src_b, reg2loc;
  logic       mem_read, mem_write, mem_to_reg, reg_write;
  logic [1:0] imm_sel;
  logic [3:0] alu_op;
  logic       timeout;

  legv8_op_decode u_dec (
    .opcode   (bus.Instr[31:21]),
    .op_class (dec_class),
    .alu_op   (dec_alu),
    .imm_sel  (dec_imm),
    .illegal  (dec_illegal)
  );

  // mem_ready in the final wait cycle takes priority over the timeout.
  assign timeout = (wait_reg == WAIT_W'(MAX_WAIT)) && !bus.mem_ready;

  always_comb begin
    state_next = state_reg;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    imm_sel    = IMM_D;
    alu_src_b  = 1'b0;
    alu_op     = ALU_AND;
    reg2loc    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        imm_sel    = dec_imm;
        state_next = dec_illegal ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        imm_sel = dec_imm;
        alu_op  = dec_alu;
        case (dec_class)
          OPC_R:    state_next = S_WB;
          OPC_LSL: begin
            alu_src_b  = 1'b1;
            state_next = S_WB;
          end
          OPC_LDUR, OPC_STUR: begin
            alu_src_b  = 1'b1;
            state_next = S_MEM;
          end
          OPC_B: begin
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            state_next = S_FETCH;
          end
          OPC_CBZ: begin
            reg2loc    = 1'b1;
            pc_src     = 1'b1;
            pc_write   = bus.Zero;
            state_next = S_FETCH;
          end
          default:  state_next = S_FAULT;
        endcase
      end
      S_MEM: begin
        if (dec_class == OPC_LDUR) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
          reg2loc   = 1'b1;
        end
        if (bus.mem_ready) begin
          state_next = (dec_class == OPC_LDUR) ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (dec_class == OPC_LDUR);
        state_next = S_FETCH;
      end
      default: state_next = S_FAULT;
    endcase
  end

  // Counter restarts on every fresh entry into a wait-capable state.
  always_comb begin
    wait_next = wait_reg;
    if ((state_next != state_reg) && (state_next == S_FETCH || state_next == S_MEM)) begin
      wait_next = '0;
    end else if ((state_reg == S_FETCH || state_reg == S_MEM) && !bus.mem_ready) begin
      wait_next = wait_reg + WAIT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_reg <= S_FETCH;
      wait_reg  <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      fault_reg <= fault_reg | (state_next == S_FAULT);
    end
  end

  assign bus.IRWrite  = resetl & ir_write;
  assign bus.PCWrite  = resetl & pc_write;
  assign bus.PCSrc    = resetl & pc_src;
  assign bus.ImmSel   = resetl ? imm_sel : 2'b00;
  assign bus.ALUSrcB  = resetl & alu_src_b;
  assign bus.ALUOp    = resetl ? alu_op : 4'b0000;
  assign bus.Reg2Loc  = resetl & reg2loc;
  assign bus.MemRead  = resetl & mem_read;
  assign bus.MemWrite = resetl & mem_write;
  assign bus.MemToReg = resetl & mem_to_reg;
  assign bus.RegWrite = resetl & reg_write;
  assign bus.fault    = resetl & fault_reg;
  assign bus.state    = resetl ? state_reg : S_FETCH;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench: each transaction queues per-cycle stimulus and expected
// control vectors, then the driver replays them and compares at the falling edge.
module tb_legv8_multicycle_ctrl;
  import legv8_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic resetl = 1'b0;

  legv8_ctrl_if bus ();

  legv8_multicycle_ctrl #(.MAX_WAIT(15), .WAIT_W(8)) dut (
    .CLK    (CLK),
    .resetl (resetl),
    .bus    (bus.master)
  );

  always #5 CLK = ~CLK;

  typedef enum {K_ADD, K_SUB, K_AND, K_ORR, K_LSL, K_LDUR, K_STUR, K_B, K_CBZ} kind_t;
  typedef struct packed {
    logic rst_n;
    logic mr;
    logic z;
  } stim_t;

  stim_t       stim_q[$];
  logic [18:0] exp_q[$];
  string       tag_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [18:0] obs_v;
  assign obs_v = {bus.state, bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.ImmSel, bus.ALUSrcB,
                  bus.ALUOp, bus.Reg2Loc, bus.MemRead, bus.MemWrite, bus.MemToReg,
                  bus.RegWrite, bus.fault};

  function automatic logic [18:0] vec(input logic [2:0] st, input logic irw, input logic pcw,
                                      input logic pcs, input logic [1:0] imm, input logic asb,
                                      input logic [3:0] alu, input logic r2l, input logic mrd,
                                      input logic mwr, input logic m2r, input logic rw,
                                      input logic f);
    return {st, irw, pcw, pcs, imm, asb, alu, r2l, mrd, mwr, m2r, rw, f};
  endfunction

  function automatic logic [18:0] fetch_wait_v();
    return vec(3'd0, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 1, 0, 0, 0, 0);
  endfunction

  function automatic logic [18:0] fault_v();
    return vec(3'd7, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] enc(input kind_t k);
    case (k)
      K_ADD:   return 32'h8B020020;
      K_SUB:   return {11'b11001011000, 21'($urandom)};
      K_AND:   return {11'b10001010000, 21'($urandom)};
      K_ORR:   return {11'b10101010000, 21'($urandom)};
      K_LSL:   return {11'b11010011011, 21'($urandom)};
      K_LDUR:  return 32'hF8408020;
      K_STUR:  return {11'b11111000000, 21'($urandom)};
      K_B:     return {6'b000101, 26'($urandom)};
      default: return {8'b10110100, 24'($urandom)};
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic rst_n, input logic mr, input logic z,
                      input logic [18:0] e);
    stim_t s;
    s.rst_n = rst_n;
    s.mr    = mr;
    s.z     = z;
    stim_q.push_back(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    stim_t       s;
    logic [18:0] e;
    string       t;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      resetl        = s.rst_n;
      bus.mem_ready = s.mr;
      bus.Zero      = s.z;
      @(negedge CLK);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, {13'd0, obs_v}, {13'd0, e});
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic run_instr(input kind_t k, input logic z, input int fw, input int mw);
    logic [1:0]  imm;
    logic [3:0]  alu;
    logic        asb, pcw, pcs, r2l;
    logic [18:0] memv;
    string       nm;
    int          n;
    nm  = k.name();
    imm = 2'b00; alu = 4'b0000; asb = 1'b0; pcw = 1'b0; pcs = 1'b0; r2l = 1'b0;
    case (k)
      K_ADD: alu = 4'b0010;
      K_SUB: alu = 4'b0110;
      K_AND: alu = 4'b0000;
      K_ORR: alu = 4'b0001;
      K_LSL: begin alu = 4'b0011; imm = 2'b11; asb = 1'b1; end
      K_LDUR, K_STUR: begin alu = 4'b0010; asb = 1'b1; end
      K_B: begin imm = 2'b10; pcw = 1'b1; pcs = 1'b1; end
      K_CBZ: begin imm = 2'b01; alu = 4'b0111; pcw = z; pcs = 1'b1; r2l = 1'b1; end
      default: ;
    endcase
    for (int i = 0; i < fw; i++) push({nm, ".fetch_wait"}, 1, 0, z, fetch_wait_v());
    push({nm, ".fetch"}, 1, 1, z, vec(3'd0, 1, 1, 0, 2'b00, 0, 4'b0000, 0, 1, 0, 0, 0, 0));
    push({nm, ".decode"}, 1, rnd_bit(), z, vec(3'd1, 0, 0, 0, imm, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    push({nm, ".exec"}, 1, rnd_bit(), z, vec(3'd2, 0, pcw, pcs, imm, asb, alu, r2l, 0, 0, 0, 0, 0));
    if (k == K_LDUR || k == K_STUR) begin
      memv = vec(3'd3, 0, 0, 0, 2'b00, 0, 4'b0000, k == K_STUR, k == K_LDUR, k == K_STUR, 0, 0, 0);
      for (int i = 0; i < mw; i++) push({nm, ".mem_wait"}, 1, 0, z, memv);
      push({nm, ".mem"}, 1, 1, z, memv);
    end
    if (k != K_B && k != K_CBZ && k != K_STUR)
      push({nm, ".wb"}, 1, rnd_bit(), z, vec(3'd4, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, k == K_LDUR, 1, 0));
    n = stim_q.size();
    bus.Instr = enc(k);
    drain();
    $display("txn %s zero=%0d fetch_wait=%0d mem_wait=%0d cycles=%0d", nm, z, fw, mw, n);
  endtask

  task automatic reset_cycle(input string tag);
    push(tag, 0, 1, 0, 19'd0);
    drain();
    $display("txn %s", tag);
  endtask

  initial begin
    bus.Instr     = 32'd0;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b0;

    push("reset0", 0, 1, 0, 19'd0);
    push("reset1", 0, 0, 1, 19'd0);
    drain();
    $display("txn reset");

    run_instr(K_ADD, 0, 0, 0);
    run_instr(K_LDUR, 0, 0, 3);
    run_instr(K_CBZ, 0, 0, 0);
    run_instr(K_CBZ, 1, 0, 0);
    run_instr(K_B, 0, 1, 0);
    run_instr(K_SUB, 1, 2, 0);
    run_instr(K_AND, 0, 0, 0);
    run_instr(K_ORR, 0, 1, 0);
    run_instr(K_LSL, 0, 0, 0);
    run_instr(K_STUR, 0, 0, 2);
    run_instr(K_ADD, 0, 15, 0);
    run_instr(K_LDUR, 1, 3, 15);

    // Fetch timeout: 16 unanswered cycles, then sticky fault.
    for (int i = 0; i < 16; i++) push("timeout.fetch_wait", 1, 0, 0, fetch_wait_v());
    for (int i = 0; i < 3; i++) push("timeout.fault", 1, rnd_bit(), 0, fault_v());
    bus.Instr = enc(K_ADD);
    drain();
    $display("txn fetch_timeout");
    reset_cycle("timeout.reset");
    run_instr(K_ORR, 0, 0, 0);

    // Illegal opcode.
    push("illegal.fetch", 1, 1, 0, vec(3'd0, 1, 1, 0, 2'b00, 0, 4'b0000, 0, 1, 0, 0, 0, 0));
    push("illegal.decode", 1, 1, 0, vec(3'd1, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    push("illegal.fault0", 1, 1, 0, fault_v());
    push("illegal.fault1", 1, 0, 1, fault_v());
    bus.Instr = 32'h00000000;
    drain();
    $display("txn illegal");
    reset_cycle("illegal.reset");

    // Reset asserted while a store is waiting in MEM.
    push("sturrst.fetch", 1, 1, 0, vec(3'd0, 1, 1, 0, 2'b00, 0, 4'b0000, 0, 1, 0, 0, 0, 0));
    push("sturrst.decode", 1, 0, 0, vec(3'd1, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    push("sturrst.exec", 1, 0, 0, vec(3'd2, 0, 0, 0, 2'b00, 1, 4'b0010, 0, 0, 0, 0, 0, 0));
    push("sturrst.mem_wait", 1, 0, 0, vec(3'd3, 0, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 1, 0, 0, 0));
    push("sturrst.reset", 0, 1, 0, 19'd0);
    bus.Instr = enc(K_STUR);
    drain();
    $display("txn stur_reset_in_mem");
    run_instr(K_ADD, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
